capture_readout_seq: RTL and testbench

//  Read-side sequencer for the 8k x 2-bit capture buffers. On start, walks the buffer's read port

---
 rtl/capture_readout_seq_pkg.sv | 14 +
 rtl/capture_readout_seq_fifo2.sv | 56 +++++
 rtl/capture_readout_seq.sv | 167 ++++++++++++++++
 tb/tb_capture_readout_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_readout_seq_pkg.sv
// Shared defaults and FSM encoding for the capture buffer read-side sequencer.
package capture_pkg;

  localparam int CAP_ADDR_W = 13;
  localparam int CAP_DATA_W = 2;
  localparam int CAP_PACK   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/capture_readout_seq_fifo2.sv
// Two-entry synchronous FIFO with occupancy count; head is visible combinationally.
// Flush empties it in one edge; storage resets to zero so an idle head reads as zero.
module readout_fifo2 #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic [W-1:0] head_dat,
  output logic         head_vld,
  output logic [1:0]   count
);

  logic [1:0][W-1:0] mem_q, mem_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              do_push, do_pop;

  always_comb begin
    do_pop  = pop_rdy && (cnt_q != 2'd0);
    do_push = push_vld && ((cnt_q != 2'd2) || do_pop);
    mem_d   = mem_q;
    if (do_push) mem_d[wr_q] = push_dat;
    wr_d  = wr_q ^ do_push;
    rd_d  = rd_q ^ do_pop;
    cnt_d = cnt_q + 2'(do_push) - 2'(do_pop);
    if (flush) begin
      wr_d  = 1'b0;
      rd_d  = 1'b0;
      cnt_d = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_dat = mem_q[rd_q];
  assign head_vld = (cnt_q != 2'd0);
  assign count    = cnt_q;

endmodule

// File: rtl/capture_readout_seq.sv
// Walks the capture RAM read port, absorbs its 1-cycle latency and packs samples into words.
// First word 6 cycles after start; reads are throttled so at most two words are ever queued.
module capture_readout_seq
  import capture_pkg::*;
#(
  parameter int  ADDR_W = CAP_ADDR_W,
  parameter int  DATA_W = CAP_DATA_W,
  parameter int  PACK   = CAP_PACK,
  localparam int OUT_W  = DATA_W * PACK
) (
  input  logic              rdclk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = (PACK > 1) ? $clog2(PACK) : 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_last_q, rd_last_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [OUT_W-1:0]  pack_q, pack_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              completing;
  logic              rd_en_c;
  logic [OUT_W-1:0]  word_c;
  logic              push_vld;
  logic [OUT_W:0]    push_dat;
  logic [OUT_W:0]    head_dat;
  logic              head_vld;
  logic [1:0]        fifo_cnt;
  logic              last_acc;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    pack_d  = pack_q;
    done_d  = 1'b0;
    busy_d  = busy_q;

    // A sample returning this cycle that closes a word will occupy a FIFO slot next edge.
    completing = rd_vld_q && ((idx_q == IDX_W'(PACK - 1)) || rd_last_q);
    rd_en_c    = (state_q == ST_READ) && (rem_q != '0) &&
                 ((fifo_cnt + {1'b0, completing}) < 2'd2);
    rd_vld_d   = rd_en_c;
    rd_last_d  = rd_en_c && (rem_q == (ADDR_W + 1)'(1));

    if (rd_en_c) begin
      addr_d = addr_q + ADDR_W'(1);
      rem_d  = rem_q - (ADDR_W + 1)'(1);
    end

    word_c = pack_q;
    word_c[idx_q*DATA_W +: DATA_W] = rd_data;
    push_vld = 1'b0;
    push_dat = {rd_last_q, word_c};
    if (rd_vld_q) begin
      if (completing) begin
        push_vld = 1'b1;
        pack_d   = '0;
        idx_d    = '0;
      end else begin
        pack_d = word_c;
        idx_d  = idx_q + IDX_W'(1);
      end
    end

    last_acc = head_vld && out_ready && head_dat[OUT_W];

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READ;
          addr_d  = start_addr;
          rem_d   = (length == '0) ? {1'b1, {ADDR_W{1'b0}}} : length;
          busy_d  = 1'b1;
        end
      end
      ST_READ: begin
        if (rd_en_c && (rem_q == (ADDR_W + 1)'(1))) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (last_acc) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything, including a same-cycle start.
    if (abort) begin
      state_d   = ST_IDLE;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      rd_vld_d  = 1'b0;
      rd_last_d = 1'b0;
      idx_d     = '0;
      pack_d    = '0;
      push_vld  = 1'b0;
    end
  end

  always_ff @(posedge rdclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      idx_q     <= '0;
      pack_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      rd_vld_q  <= rd_vld_d;
      rd_last_q <= rd_last_d;
      idx_q     <= idx_d;
      pack_q    <= pack_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  readout_fifo2 #(.W(OUT_W + 1)) u_fifo (
    .clk      (rdclk),
    .rst      (rst),
    .flush    (abort),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_rdy  (out_ready),
    .head_dat (head_dat),
    .head_vld (head_vld),
    .count    (fifo_cnt)
  );

  assign rd_addr   = addr_q;
  assign rd_en     = rd_en_c;
  assign out_data  = head_dat[OUT_W-1:0];
  assign out_last  = head_dat[OUT_W];
  assign out_valid = head_vld;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_capture_readout_seq.sv
// Scoreboarded bench: stimulus pushes expected addresses/words, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_capture_readout_seq;

  localparam int AW = 13, DW = 2, PK = 4, OW = 8, DEPTH = 8192;

  logic          rdclk = 1'b0;
  logic          rst = 1'b0;
  logic          start, abort, out_ready;
  logic [AW-1:0] start_addr;
  logic [AW:0]   length;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [DW-1:0] rd_data = '0;
  logic [OW-1:0] out_data;
  logic          out_valid, out_last, busy, done;

  capture_readout_seq dut (
    .rdclk(rdclk), .rst(rst), .start(start), .abort(abort),
    .start_addr(start_addr), .length(length), .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_data(rd_data), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 rdclk = ~rdclk;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge rdclk) if (rd_en) rd_data <= mem[rd_addr];

  typedef struct packed { logic [OW-1:0] d; logic l; } wexp_t;
  wexp_t exp_w[$];
  int    exp_a[$];
  int    n_cmp = 0, n_err = 0, done_cnt = 0, runs = 0, ready_mode = 0;

  task automatic chk(input string nm, input longint act, input longint want);
    n_cmp++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Reference: sample k comes from (sa+k) mod depth and lands in slot k%PK of word k/PK.
  task automatic push_model(input int sa, input int len);
    int n;
    logic [OW-1:0] w;
    n = (len == 0) ? DEPTH : len;
    w = '0;
    for (int k = 0; k < n; k++) begin
      exp_a.push_back((sa + k) % DEPTH);
      w[(k % PK) * DW +: DW] = mem[(sa + k) % DEPTH];
      if ((k % PK == PK - 1) || (k == n - 1)) begin
        exp_w.push_back('{d: w, l: (k == n - 1)});
        w = '0;
      end
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge rdclk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 99) < 30);
        default: out_ready = 1'b0;
      endcase
    end
  end

  logic          done_pend = 1'b0, stall_q = 1'b0;
  logic [OW-1:0] hold_d;
  logic          hold_l;
  always @(negedge rdclk) begin
    logic  set_pend;
    int    a;
    wexp_t e;
    set_pend = 1'b0;
    if (rst || abort) begin
      done_pend = 1'b0;
      stall_q   = 1'b0;
    end else begin
      if (exp_a.size() == 0) chk("rd_en_idle", rd_en, 0);
      else if (rd_en) begin
        a = exp_a.pop_front();
        chk("rd_addr", rd_addr, a);
      end
      if (stall_q) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hold_d);
        chk("hold_last", out_last, hold_l);
      end
      if (exp_w.size() == 0) chk("out_valid_idle", out_valid, 0);
      else if (out_valid && out_ready) begin
        e = exp_w.pop_front();
        chk("word_data", out_data, e.d);
        chk("word_last", out_last, e.l);
        set_pend = e.l;
      end
      if (done_pend) begin
        chk("done_pulse", done, 1);
        chk("busy_fall", busy, 0);
        done_cnt++;
      end else chk("done_idle", done, 0);
      done_pend = set_pend;
      stall_q   = out_valid && !out_ready;
      hold_d    = out_data;
      hold_l    = out_last;
    end
  end

  task automatic start_run(input int sa, input int len);
    logic [31:0] s, l;
    push_model(sa, len);
    s = sa;
    l = len;
    start_addr = s[AW-1:0];
    length     = l[AW:0];
    start      = 1'b1;
    @(posedge rdclk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, input bit mid_start, output int first);
    int cyc;
    cyc   = 1;
    first = out_valid ? 1 : -1;
    while (!done && cyc < lim) begin
      @(posedge rdclk); #1;
      cyc++;
      start = mid_start && (cyc == 3);
      if (mid_start && cyc == 3) start_addr = AW'($urandom);
      if (first < 0 && out_valid) first = cyc;
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    chk("addr_q_empty", exp_a.size(), 0);
    chk("word_q_empty", exp_w.size(), 0);
    runs++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    int first, sa, len, saved;
    start = 0; abort = 0; start_addr = '0; length = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = i[1:0];
    #2 rst = 1'b1;
    #2;
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (3) @(posedge rdclk);
    #1 rst = 1'b0;
    @(posedge rdclk); #1;

    // Two full words 0xE4, latency to first word
    start_run(0, 8);
    chk("rd_en_cycle1", rd_en, 1);
    chk("busy_cycle1", busy, 1);
    wait_done(400, 0, first);
    chk("first_valid_cycle", first, 6);

    // Address wrap, then a partial word (back-to-back starts land in the done cycle)
    start_run('h1FFE, 4);
    wait_done(400, 0, first);
    start_run(0, 6);
    wait_done(400, 0, first);

    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);

    // Full buffer
    start_run($urandom_range(0, DEPTH - 1), 0);
    wait_done(40000, 0, first);

    // Throttled consumer with an ignored start mid-run
    ready_mode = 1;
    start_run($urandom_range(0, DEPTH - 1), 64);
    wait_done(4000, 1, first);

    for (int r = 0; r < 6; r++) begin
      ready_mode = $urandom_range(0, 1);
      sa  = $urandom_range(0, DEPTH - 1);
      len = $urandom_range(1, 150);
      start_run(sa, len);
      wait_done(len * 20 + 100, r[0], first);
    end

    // Abort mid-READ
    ready_mode = 0;
    @(posedge rdclk); #1;
    saved = done_cnt;
    start_run($urandom_range(0, DEPTH - 1), 100);
    repeat (10) @(posedge rdclk);
    #1 abort = 1'b1;
    start = 1'b1;
    @(posedge rdclk); #1;
    abort = 1'b0;
    start = 1'b0;
    exp_a.delete();
    exp_w.delete();
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rd_en", rd_en, 0);
    repeat (5) @(posedge rdclk);
    #1 chk("abort_no_done", done_cnt, saved);
    start_run($urandom_range(0, DEPTH - 1), 20);
    wait_done(400, 0, first);

    // Reset mid-DRAIN with a stalled consumer
    ready_mode = 2;
    repeat (2) @(posedge rdclk);
    #1 saved = done_cnt;
    start_run($urandom_range(0, DEPTH - 1), 8);
    for (int c = 0; c < 60 && exp_a.size() != 0; c++) begin
      @(posedge rdclk); #1;
    end
    @(posedge rdclk); #1;
    chk("drain_busy", busy, 1);
    chk("drain_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_rd_en", rd_en, 0);
    chk("mrst_rd_addr", rd_addr, 0);
    chk("mrst_out_data", out_data, 0);
    chk("mrst_out_last", out_last, 0);
    @(posedge rdclk); #1;
    rst = 1'b0;
    exp_a.delete();
    exp_w.delete();
    ready_mode = 0;
    repeat (3) @(posedge rdclk);
    #1 chk("mrst_no_done", done_cnt, saved);
    start_run($urandom_range(0, DEPTH - 1), 13);
    wait_done(400, 0, first);

    @(posedge rdclk); #1;
    chk("done_total", done_cnt, runs);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
